// File: rtl/oled_region_renderer.sv
// ---------------------------------------------------------------------------
// oled_region_renderer
//
// Renders RGB565 colour for a 96x64 OLED from a small set of programmable
// rectangular-in-index (linear range) colour regions. Each region has a
// shadow descriptor (written by the configuration port) and an active
// descriptor (used for rendering). Shadow contents are copied to active on
// frame_begin so a frame never shows a half-updated configuration. Regions
// flagged as blinking are hidden during alternating blink half-periods.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   frame_begin    in   1   start-of-frame pulse from the OLED driver
//   pixel_index    in  13   linear index of the requested pixel
//   cfg_we         in   1   configuration write strobe
//   cfg_sel        in   3   target region number
//   cfg_data       in  44   {enable, blink, start[12:0], end[12:0], color[15:0]}
//   pixel_data     out 16   registered colour for the previous pixel_index
//   commit_pending out  1   shadow differs from active, waiting for frame_begin
//   blink_phase    out  1   1 = blinking regions currently hidden
// ---------------------------------------------------------------------------
module oled_region_renderer #(
    parameter int          NUM_REGIONS  = 4,
    parameter int          PIX_COUNT    = 6144,
    parameter logic [15:0] BG_COLOR     = 16'h07E0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_sel,
    input  logic [43:0] cfg_data,
    output logic [15:0] pixel_data,
    output logic        commit_pending,
    output logic        blink_phase
);

    localparam logic [3:0]  LP_NUM_REGIONS = 4'(NUM_REGIONS);
    localparam logic [13:0] LP_PIX_COUNT   = 14'(PIX_COUNT);
    localparam logic [7:0]  LP_BLINK_LAST  = 8'(BLINK_FRAMES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [43:0] r_shadow [NUM_REGIONS];
    logic [43:0] r_active [NUM_REGIONS];
    logic [7:0]  r_frame_cnt;
    logic        r_blink;
    logic [15:0] r_pixel_data;

    logic        w_cfg_valid;
    logic        w_in_range;
    logic [15:0] w_color;

    assign w_cfg_valid = cfg_we && ({1'b0, cfg_sel} < LP_NUM_REGIONS);
    assign w_in_range  = {1'b0, pixel_index} < LP_PIX_COUNT;

    // Descriptor storage. A write landing on the same edge as frame_begin is
    // forwarded straight into the active copy so the commit includes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (w_cfg_valid && (cfg_sel == 3'(i))) begin
                    r_shadow[i] <= cfg_data;
                end
                if (frame_begin) begin
                    r_active[i] <= (w_cfg_valid && (cfg_sel == 3'(i))) ? cfg_data : r_shadow[i];
                end
            end
        end
    end

    // Commit FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commit FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cfg_valid && !frame_begin) begin
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_begin) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign commit_pending = (r_state == PENDING);

    // Blink timing: counter wraps on the frame that would reach BLINK_FRAMES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (frame_begin) begin
            if (r_frame_cnt == LP_BLINK_LAST) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Region match. Scanning from the highest region down lets the
    // lowest-numbered match overwrite the others. Empty ranges (start >= end)
    // can never satisfy both bounds.
    always_comb begin
        w_color = BG_COLOR;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (r_active[i][43] &&
                (r_active[i][41:29] <= pixel_index) &&
                (pixel_index < r_active[i][28:16]) &&
                !(r_active[i][42] && r_blink)) begin
                w_color = r_active[i][15:0];
            end
        end
        if (!w_in_range) begin
            w_color = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_data <= BG_COLOR;
        end else begin
            r_pixel_data <= w_color;
        end
    end

    assign pixel_data  = r_pixel_data;
    assign blink_phase = r_blink;

endmodule

// File: tb/tb_oled_region_renderer.sv
// ---------------------------------------------------------------------------
// tb_oled_region_renderer
//
// Directed bench for oled_region_renderer (BLINK_FRAMES = 2). Expected pixel
// colours are pushed to a queue as each pixel_index is driven and popped when
// the registered output is sampled one clock later. Control outputs are
// compared directly.
// ---------------------------------------------------------------------------
module tb_oled_region_renderer;

    localparam logic [15:0] BG = 16'h07E0;

    logic        clk;
    logic        reset_n;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [43:0] cfg_data;
    logic [15:0] pixel_data;
    logic        commit_pending;
    logic        blink_phase;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q [$];

    oled_region_renderer #(
        .NUM_REGIONS (4),
        .PIX_COUNT   (6144),
        .BG_COLOR    (16'h07E0),
        .BLINK_FRAMES(2)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_begin   (frame_begin),
        .pixel_index   (pixel_index),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .pixel_data    (pixel_data),
        .commit_pending(commit_pending),
        .blink_phase   (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] desc(input logic en, input logic bl,
                                         input logic [12:0] s, input logic [12:0] e,
                                         input logic [15:0] c);
        return {en, bl, s, e, c};
    endfunction

    // Drive one pixel index for one cycle and score the registered result.
    task automatic pix(input logic [12:0] idx, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        pixel_index = idx;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, pixel_data, e);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [43:0] d, input logic [15:0] exp);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        pix(pixel_index, exp, "wr_pix");
        cfg_we   = 1'b0;
    endtask

    task automatic fb(input logic [15:0] exp);
        frame_begin = 1'b1;
        pix(pixel_index, exp, "fb_pix");
        frame_begin = 1'b0;
    endtask

    task automatic pulse_reset();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_pix",     pixel_data, BG);
        check("rst_pending", 16'(commit_pending), 16'd0);
        check("rst_blink",   16'(blink_phase), 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        frame_begin = 1'b0;
        pixel_index = '0;
        cfg_we      = 1'b0;
        cfg_sel     = '0;
        cfg_data    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_pix",     pixel_data, BG);
        check("reset_pending", 16'(commit_pending), 16'd0);
        check("reset_blink",   16'(blink_phase), 16'd0);
        reset_n = 1'b1;
        pix(13'd10, BG, "post_reset");

        // Single region, full sweep
        wr(3'd0, desc(1'b1, 1'b0, 13'd3000, 13'd5000, 16'hF800), BG);
        check("t1_pending", 16'(commit_pending), 16'd1);
        fb(BG);
        check("t1_commit", 16'(commit_pending), 16'd0);
        for (int i = 0; i < 6144; i++) begin
            pix(13'(i), ((i >= 3000) && (i < 5000)) ? 16'hF800 : BG, "sweep");
        end

        // Shadow write does not disturb rendering until frame_begin
        pix(13'd4000, 16'hF800, "t2_before");
        wr(3'd0, desc(1'b1, 1'b0, 13'd3000, 13'd5000, 16'h001F), 16'hF800);
        check("t2_pending", 16'(commit_pending), 16'd1);
        pix(13'd4000, 16'hF800, "t2_held");
        fb(16'hF800);
        check("t2_commit", 16'(commit_pending), 16'd0);
        pix(13'd4000, 16'h001F, "t2_new");
        check("t2_blink", 16'(blink_phase), 16'd1);

        // Priority, half-open bounds, PIX_COUNT limit, empty range
        wr(3'd0, desc(1'b1, 1'b0, 13'd0,    13'd100,  16'h001F), 16'h001F);
        wr(3'd1, desc(1'b1, 1'b0, 13'd50,   13'd200,  16'hF800), 16'h001F);
        wr(3'd2, desc(1'b1, 1'b0, 13'd6100, 13'd8000, 16'h1234), 16'h001F);
        wr(3'd3, desc(1'b1, 1'b0, 13'd500,  13'd500,  16'hABCD), 16'h001F);
        fb(16'h001F);
        pix(13'd60,   16'h001F, "prio_60");
        pix(13'd150,  16'hF800, "prio_150");
        pix(13'd250,  BG,       "prio_250");
        pix(13'd99,   16'h001F, "bound_99");
        pix(13'd100,  16'hF800, "bound_100");
        pix(13'd199,  16'hF800, "bound_199");
        pix(13'd200,  BG,       "bound_200");
        pix(13'd6143, 16'h1234, "pix_6143");
        pix(13'd6144, BG,       "pix_6144");
        pix(13'd6200, BG,       "pix_6200");
        pix(13'd500,  BG,       "empty_500");

        // Write coincident with frame_begin commits immediately
        cfg_we      = 1'b1;
        cfg_sel     = 3'd0;
        cfg_data    = desc(1'b1, 1'b0, 13'd0, 13'd100, 16'h7777);
        frame_begin = 1'b1;
        pix(13'd60, 16'h001F, "coinc_old");
        cfg_we      = 1'b0;
        frame_begin = 1'b0;
        check("coinc_pending", 16'(commit_pending), 16'd0);
        pix(13'd60, 16'h7777, "coinc_new");
        check("coinc_blink", 16'(blink_phase), 16'd0);

        // Out-of-range region select is ignored
        wr(3'd7, desc(1'b1, 1'b0, 13'd0, 13'd6144, 16'hFFFF), 16'h7777);
        check("sel7_pending", 16'(commit_pending), 16'd0);
        fb(16'h7777);
        pix(13'd60, 16'h7777, "sel7_pix");

        // Reset with a commit pending discards everything
        wr(3'd0, desc(1'b1, 1'b0, 13'd0, 13'd6144, 16'hABCD), 16'h7777);
        check("t5_pending", 16'(commit_pending), 16'd1);
        pulse_reset();
        pix(13'd60, BG, "t5_after");
        fb(BG);
        pix(13'd60, BG, "t5_fb");
        check("t5_commit", 16'(commit_pending), 16'd0);

        // Blinking region with BLINK_FRAMES = 2
        pulse_reset();
        pix(13'd5, BG, "blink_pre");
        wr(3'd0, desc(1'b1, 1'b1, 13'd0, 13'd10, 16'hFFFF), BG);
        fb(BG);
        pix(13'd5, 16'hFFFF, "blink_f1");
        check("blink_f1_phase", 16'(blink_phase), 16'd0);
        fb(16'hFFFF);
        check("blink_f2_phase", 16'(blink_phase), 16'd1);
        pix(13'd5, BG, "blink_f2");
        fb(BG);
        check("blink_f3_phase", 16'(blink_phase), 16'd1);
        fb(BG);
        check("blink_f4_phase", 16'(blink_phase), 16'd0);
        pix(13'd5, 16'hFFFF, "blink_f4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
